// File: rtl/median_seq_n.sv
// median_seq_n: serial median of an N-sample window by K passes of max extraction.
// Define MEDIAN_MINMAX_EN to add the DMIN/DMAX window statistics outputs.
module median_seq_n #(
  parameter int WIDTH = 8,
  parameter int N     = 9
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DI,
  input  logic             DSI,
  output logic             BUSY,
  output logic             DROP,
  output logic [WIDTH-1:0] DO,
  output logic             DSO
`ifdef MEDIAN_MINMAX_EN
  ,
  output logic [WIDTH-1:0] DMIN,
  output logic [WIDTH-1:0] DMAX
`endif
);

  localparam int K  = (N + 1) / 2;
  localparam int CW = $clog2(N + 1);

  if ((N % 2) == 0 || N < 3 || N > 31) begin : g_bad_n
    $error("median_seq_n: N must be odd and within 3..31");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PASS,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    r_k;
  logic [CW-1:0]    r_j;
  logic [CW-1:0]    r_m;
  logic [WIDTH-1:0] r_chain [N];
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_do;
  logic             r_dso;
  logic             r_drop;

  logic             w_busy;
  logic             w_accept;
  logic [WIDTH-1:0] w_head;
  logic [WIDTH-1:0] w_max;
  logic [WIDTH-1:0] w_min;
  logic             w_first;
  logic             w_pend;
  logic             w_last;
  int               w_tail;

  assign w_busy   = (r_state == S_PASS);
  assign w_accept = DSI && !w_busy;
  assign w_head   = r_chain[0];
  assign w_max    = (r_a > w_head) ? r_a : w_head;
  assign w_min    = (r_a > w_head) ? w_head : r_a;
  assign w_first  = (r_j == CW'(1));
  assign w_pend   = (r_j == r_m);
  assign w_last   = w_pend && (r_k == CW'(K));
  // the live set always occupies R[0..M-2] once the head is popped
  assign w_tail   = int'(r_m) - 2;

  always_ff @(posedge CLK) begin
    if (w_busy) begin
      r_a <= w_first ? w_head : w_max;
      for (int i = 0; i < N - 1; i++) begin
        if (!w_first && i == w_tail) begin
          r_chain[i] <= w_min;
        end else begin
          r_chain[i] <= r_chain[i+1];
        end
      end
    end else if (w_accept) begin
      for (int i = 0; i < N - 1; i++) begin
        r_chain[i] <= r_chain[i+1];
      end
      r_chain[N-1] <= DI;
    end
  end

`ifdef MEDIAN_MINMAX_EN
  logic [WIDTH-1:0] r_rmin;
  logic [WIDTH-1:0] r_pmax;
  logic [WIDTH-1:0] r_dmin;
  logic [WIDTH-1:0] r_dmax;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_k     <= '0;
      r_j     <= '0;
      r_m     <= '0;
      r_do    <= '0;
      r_dso   <= 1'b0;
      r_drop  <= 1'b0;
`ifdef MEDIAN_MINMAX_EN
      r_rmin  <= '0;
      r_pmax  <= '0;
      r_dmin  <= '0;
      r_dmax  <= '0;
`endif
    end else begin
      r_dso  <= 1'b0;
      r_drop <= DSI && w_busy;
`ifdef MEDIAN_MINMAX_EN
      if (w_accept) begin
        if (r_state == S_LOAD) begin
          r_rmin <= (DI < r_rmin) ? DI : r_rmin;
        end else begin
          r_rmin <= DI;
        end
      end
      if (w_busy && w_pend && r_k == CW'(1)) begin
        r_pmax <= w_max;
      end
`endif
      unique case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (DSI) begin
            r_cnt   <= CW'(1);
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (DSI) begin
            if (r_cnt == CW'(N - 1)) begin
              r_cnt   <= '0;
              r_k     <= CW'(1);
              r_j     <= CW'(1);
              r_m     <= CW'(N);
              r_state <= S_PASS;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_PASS: begin
          if (w_last) begin
            r_state <= S_DONE;
          end else if (w_pend) begin
            r_k <= r_k + CW'(1);
            r_j <= CW'(1);
            r_m <= r_m - CW'(1);
          end else begin
            r_j <= r_j + CW'(1);
          end
        end
        S_DONE: begin
          r_dso <= 1'b1;
          r_do  <= r_a;
`ifdef MEDIAN_MINMAX_EN
          r_dmin <= r_rmin;
          r_dmax <= r_pmax;
`endif
          if (DSI) begin
            r_cnt   <= CW'(1);
            r_state <= S_LOAD;
          end else begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign BUSY = w_busy;
  assign DROP = r_drop;
  assign DO   = r_do;
  assign DSO  = r_dso;
`ifdef MEDIAN_MINMAX_EN
  assign DMIN = r_dmin;
  assign DMAX = r_dmax;
`endif

endmodule

// File: tb/tb_median_seq_n.sv
// tb_median_seq_n: randomized scoreboard bench for median_seq_n (N=9 and N=3).
// Expected medians come from sorting each accepted window in a queue.
module tb_median_seq_n;
  localparam int N = 9;
  localparam int L = 36;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dsi = 1'b0;
  logic [7:0] di  = '0;
  logic       busy, drop, dso;
  logic [7:0] dout;
  logic       d3_dsi = 1'b0;
  logic [7:0] d3_di  = '0;
  logic       b3, dr3, dso3;
  logic [7:0] do3;
`ifdef MEDIAN_MINMAX_EN
  logic [7:0] dmin, dmax, dmin3, dmax3;
  logic [7:0] mn_q[$];
  logic [7:0] mx_q[$];
`endif

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  bit         rst_q = 1'b1;
  logic [7:0] win[$];
  logic [7:0] exp_q[$];
  int         lat_q[$];
  int         drop_exp = 0;
  int         drop_seen = 0;
  logic [7:0] do_prev = '0;
  int         t1[9] = '{9, 1, 8, 2, 7, 3, 6, 4, 5};

  always #5 clk = ~clk;

  median_seq_n #(.WIDTH(8), .N(N)) u_dut (
    .CLK(clk), .RST(rst), .DI(di), .DSI(dsi),
    .BUSY(busy), .DROP(drop), .DO(dout), .DSO(dso)
`ifdef MEDIAN_MINMAX_EN
    , .DMIN(dmin), .DMAX(dmax)
`endif
  );

  median_seq_n #(.WIDTH(8), .N(3)) u_dut3 (
    .CLK(clk), .RST(rst), .DI(d3_di), .DSI(d3_dsi),
    .BUSY(b3), .DROP(dr3), .DO(do3), .DSO(dso3)
`ifdef MEDIAN_MINMAX_EN
    , .DMIN(dmin3), .DMAX(dmax3)
`endif
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic model_accept(input logic [7:0] v, input int ac);
    logic [7:0] s[$];
    win.push_back(v);
    if (win.size() == N) begin
      s = win;
      s.sort();
      exp_q.push_back(s[N/2]);
      lat_q.push_back(ac);
`ifdef MEDIAN_MINMAX_EN
      mn_q.push_back(s[0]);
      mx_q.push_back(s[N-1]);
`endif
      win.delete();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] v, input int gap);
    int g;
    dsi = 1'b0;
    repeat (gap) tick();
    g = 0;
    while (busy && g < 200) begin
      tick();
      g++;
    end
    if (g >= 200) chk("busy_timeout", 1, 0);
    dsi = 1'b1;
    di  = v;
    model_accept(v, cyc + 1);
    tick();
    dsi = 1'b0;
  endtask

  always @(posedge clk) begin
    cyc++;
    rst_q = rst;
  end

  always @(negedge clk) begin
    logic [7:0] e;
    int         a;
    if (dso) begin
      if (exp_q.size() == 0) begin
        chk("dso_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        a = lat_q.pop_front();
        chk("do", int'(dout), int'(e));
        chk("latency", cyc - a, L);
`ifdef MEDIAN_MINMAX_EN
        chk("dmin", int'(dmin), int'(mn_q.pop_front()));
        chk("dmax", int'(dmax), int'(mx_q.pop_front()));
`endif
      end
    end
    if (drop) drop_seen++;
    if (!dso && !rst_q && dout !== do_prev) chk("do_hold", int'(dout), int'(do_prev));
    do_prev = dout;
  end

  initial begin
    int g;
    int c0;
    tick();
    tick();
    tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_drop", int'(drop), 0);
    chk("rst_dso", int'(dso), 0);
    chk("rst_do", int'(dout), 0);
    rst = 1'b0;

    foreach (t1[i]) send(8'(t1[i]), 0);

    repeat (9) send(8'hAA, 0);
    repeat (4) send(8'd0, 0);
    repeat (5) send(8'd255, 0);
    repeat (4) send(8'd255, 0);
    repeat (5) send(8'd0, 0);

    foreach (t1[i]) send(8'(t1[i]), int'($urandom_range(0, 3)));

    // strobes while busy must be discarded and flagged
    foreach (t1[i]) send(8'(t1[i]), 0);
    for (int s = 0; s < 3; s++) begin
      tick();
      tick();
      chk("busy_for_drop", int'(busy), 1);
      dsi = 1'b1;
      di  = 8'($urandom);
      drop_exp++;
      tick();
      dsi = 1'b0;
    end

    // abort a window mid-computation
    foreach (t1[i]) send(8'(t1[i]), 0);
    repeat (9) tick();
    rst = 1'b1;
    void'(exp_q.pop_back());
    void'(lat_q.pop_back());
`ifdef MEDIAN_MINMAX_EN
    void'(mn_q.pop_back());
    void'(mx_q.pop_back());
`endif
    tick();
    rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_do", int'(dout), 0);
    chk("abort_dso", int'(dso), 0);
    repeat (40) tick();
    foreach (t1[i]) send(8'(t1[i]), 0);

    for (int w = 0; w < 6; w++) begin
      for (int i = 0; i < N; i++) begin
        if (w % 2 == 0) send(8'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
        else send(8'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end
    end

    d3_dsi = 1'b1;
    d3_di  = 8'd3;
    tick();
    d3_di  = 8'd1;
    tick();
    d3_di  = 8'd2;
    tick();
    c0 = cyc;
    d3_dsi = 1'b0;
    g = 0;
    while (!dso3 && g < 20) begin
      tick();
      g++;
    end
    chk("n3_latency", cyc - c0, 6);
    chk("n3_do", int'(do3), 2);

    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      tick();
      g++;
    end
    tick();
    chk("pending", exp_q.size(), 0);
    chk("drops", drop_seen, drop_exp);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
